// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Helpers shared by the read- and write-side FIFO controllers.
//   - ptr_w()    : pointer width for a given depth (address bits + lap bit)
//   - bin2gray() : binary to Gray conversion, up to 32 bits; callers size-cast
//                  the result down to their pointer width.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_w(FIFO_DEPTH_DEF);

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync
//   N-bit two-flop synchronizer for Gray-coded FIFO pointers. Only one bit of
//   the input changes per update, so each sampled value is either the old or
//   the new pointer, never a mix.
// Ports:
//   clk    destination-domain clock
//   rst_n  asynchronous active-low reset (both stages clear to 0)
//   d      pointer from the source domain
//   q      pointer synchronized to clk (2-edge latency)
module fifo_ptr_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side controller of the asynchronous FIFO (read clock domain only).
//   Owns the read pointer, addresses the FIFO memory, detects empty against
//   the write pointer, and presents popped words through a registered
//   valid/ready stage that sustains one word per clock.
// Configuration macro:
//   FIFO_RD_SYNC_EN  defined: WPTR_GRAY passes through an internal two-flop
//                    synchronizer; undefined: WPTR_GRAY must already be
//                    synchronous to R_CLK and is used directly.
// Ports:
//   R_CLK        read clock
//   R_RST        asynchronous active-low reset
//   WPTR_GRAY    Gray write pointer (ADDR_W+1 bits)
//   MEM_RD_DATA  combinational memory data at R_ADDR
//   R_ADDR       memory read address (rbin modulo depth)
//   RPTR_GRAY    registered Gray read pointer for the write domain
//   RD_DATA      registered output word
//   RD_VALID     RD_DATA holds an unconsumed word
//   RD_READY     consumer accepts RD_DATA this cycle
//   EMPTY        memory holds no unread entry (output register excluded)
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH),
    localparam int PTR_W      = ptr_w(FIFO_DEPTH)
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [PTR_W-1:0]      WPTR_GRAY,
    input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
    output logic [ADDR_W-1:0]     R_ADDR,
    output logic [PTR_W-1:0]      RPTR_GRAY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic                  EMPTY
);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray;
    logic [PTR_W-1:0] wq;
    logic [PTR_W-1:0] rbin_nxt;
    logic [PTR_W-1:0] rgray_nxt;
    logic             pop;

`ifdef FIFO_RD_SYNC_EN
    fifo_ptr_sync #(.W(PTR_W)) u_wptr_sync (
        .clk   (R_CLK),
        .rst_n (R_RST),
        .d     (WPTR_GRAY),
        .q     (wq)
    );
`else
    assign wq = WPTR_GRAY;
`endif

    // Gray compare including the lap bit: equal means nothing unread.
    assign EMPTY = (rgray == wq);

    // Pop when data exists and the output stage is free or being drained
    // this same cycle, so back-to-back words leave no bubble.
    assign pop = !EMPTY && (!RD_VALID || RD_READY);

    assign rbin_nxt  = rbin + 1'b1;
    assign rgray_nxt = PTR_W'(bin2gray(32'(rbin_nxt)));

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin     <= '0;
            rgray    <= '0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else if (pop) begin
            RD_DATA  <= MEM_RD_DATA;
            rbin     <= rbin_nxt;
            rgray    <= rgray_nxt;
            RD_VALID <= 1'b1;
        end else if (RD_VALID && RD_READY) begin
            RD_VALID <= 1'b0;
        end
    end

    // The write domain samples this asynchronously, so it must be a bare flop.
    assign RPTR_GRAY = rgray;
    assign R_ADDR    = rbin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 4;
`ifdef FIFO_RD_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          R_CLK = 1'b0;
    logic          R_RST;
    logic [PW-1:0] WPTR_GRAY;
    logic [DW-1:0] MEM_RD_DATA;
    logic [AW-1:0] R_ADDR;
    logic [PW-1:0] RPTR_GRAY;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic          EMPTY;

    logic [DW-1:0] mem [DEPTH];
    assign MEM_RD_DATA = mem[R_ADDR];

    always #5 R_CLK = ~R_CLK;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .R_CLK       (R_CLK),
        .R_RST       (R_RST),
        .WPTR_GRAY   (WPTR_GRAY),
        .MEM_RD_DATA (MEM_RD_DATA),
        .R_ADDR      (R_ADDR),
        .RPTR_GRAY   (RPTR_GRAY),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .RD_READY    (RD_READY),
        .EMPTY       (EMPTY)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: word counts since reset plus a log of written data.
    logic [DW-1:0] wlog [4096];
    int            wcnt;      // words written
    int            rcnt;      // words moved into the output stage
    int            acc;       // words accepted by the consumer
    int            whist [2]; // write counts as seen through the synchronizer
    logic          m_valid;
    logic [DW-1:0] m_data;

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int vis();
        if (SYNC_LAT == 0) return wcnt;
        return whist[SYNC_LAT-1];
    endfunction

    task automatic model_reset();
        wcnt = 0; rcnt = 0; acc = 0;
        whist[0] = 0; whist[1] = 0;
        m_valid = 1'b0; m_data = '0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        if (wcnt - rcnt < DEPTH) begin
            mem[wcnt % DEPTH] = d;
            wlog[wcnt] = d;
            wcnt++;
            WPTR_GRAY = gray(wcnt);
        end
    endtask

    // One clock: called just after a rising edge, returns just after the next.
    task automatic step(input logic rdy);
        logic          pop;
        logic [PW-1:0] prev_g;
        RD_READY = rdy;
        #1;
        chk("empty", 32'(EMPTY), 32'(vis() == rcnt));
        pop = (vis() != rcnt) && (!m_valid || rdy);
        if (RD_VALID && rdy) begin
            chk("accept_data", 32'(RD_DATA), 32'(wlog[acc]));
            acc++;
        end
        prev_g = RPTR_GRAY;
        @(posedge R_CLK);
        if (pop) begin
            m_data  = wlog[rcnt];
            rcnt++;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        whist[1] = whist[0];
        whist[0] = wcnt;
        #1;
        chk("rd_valid", 32'(RD_VALID), 32'(m_valid));
        if (m_valid) chk("rd_data", 32'(RD_DATA), 32'(m_data));
        chk("rptr_gray", 32'(RPTR_GRAY), 32'(gray(rcnt)));
        chk("r_addr", 32'(R_ADDR), 32'(rcnt % DEPTH));
        if (pop) chk("gray_1bit", $countones(prev_g ^ RPTR_GRAY), 1);
    endtask

    task automatic do_reset();
        R_RST = 1'b0;
        WPTR_GRAY = '0;
        RD_READY = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(RD_VALID), 0);
        chk("rst_rptr", 32'(RPTR_GRAY), 0);
        chk("rst_addr", 32'(R_ADDR), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        @(negedge R_CLK);
        R_RST = 1'b1;
        @(posedge R_CLK);
        #1;
    endtask

    initial begin
        int first_v, last_v, nvalid, n;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        do_reset();
        chk("rst_data", 32'(RD_DATA), 0);

        // Single word held under backpressure, then consumed.
        push(8'hA5);
        repeat (SYNC_LAT + 1) step(1'b0);
        chk("single_valid", 32'(RD_VALID), 1);
        chk("single_data", 32'(RD_DATA), 32'h A5);
        repeat (3) step(1'b0);
        chk("single_hold", 32'(RD_DATA), 32'h A5);
        step(1'b1);
        chk("single_done", 32'(RD_VALID), 0);

        // Streaming: 8 words with RD_READY high, no bubbles.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        first_v = -1; last_v = -1; nvalid = 0;
        for (int c = 0; c < 8 + SYNC_LAT + 3; c++) begin
            step(1'b1);
            if (RD_VALID) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nvalid++;
            end
        end
        chk("stream_count", nvalid, 8);
        chk("stream_span", last_v - first_v + 1, 8);
        chk("stream_addr", 32'(R_ADDR), 0);
        chk("stream_rptr", 32'(RPTR_GRAY), 32'b1100);
        chk("stream_acc", acc, 8);

        // Backpressure: 3 words, RD_READY toggling.
        do_reset();
        push(8'h31); push(8'h32); push(8'h33);
        for (int c = 0; c < 16; c++) step(c[0]);
        chk("bp_acc", acc, 3);
        chk("bp_empty", 32'(EMPTY), 1);
        chk("bp_valid", 32'(RD_VALID), 0);

        // Wrap: 20 words through the 8-deep FIFO with random flow control.
        do_reset();
        n = 0;
        for (int c = 0; c < 2000 && n < 20; c++) begin
            if (wcnt - rcnt < DEPTH && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                n++;
            end
            step(1'($urandom_range(0, 1)));
        end
        repeat (24) step(1'b1);
        chk("wrap_words", n, 20);
        chk("wrap_acc", acc, 20);
        chk("wrap_rptr", 32'(RPTR_GRAY), 32'(gray(20)));

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0) push(8'($urandom));
            step(1'($urandom_range(0, 3) != 0));
        end
        repeat (24) step(1'b1);
        chk("rand_drain", acc, wcnt);

        // Reset mid-stream with RD_VALID high: clears without a clock edge.
        push(8'h77); push(8'h78);
        repeat (SYNC_LAT + 2) step(1'b0);
        chk("pre_rst_valid", 32'(RD_VALID), 1);
        #3;
        R_RST = 1'b0;
        WPTR_GRAY = '0;
        #1;
        chk("mid_rst_valid", 32'(RD_VALID), 0);
        chk("mid_rst_rptr", 32'(RPTR_GRAY), 0);
        chk("mid_rst_empty", 32'(EMPTY), 1);
        do_reset();
        push(8'h5A);
        repeat (SYNC_LAT + 1) step(1'b1);
        chk("post_rst_data", 32'(RD_DATA), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
